// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse-timing FSM family.
// The state encodings are reused by sibling FSMs, so their 2-bit values are fixed here.
// The output widths of pulse_meter are also defined here so that the interface and
// the top module agree on them.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  localparam int PULSE_CNT_W = 8;
  localparam int DEBUG_W     = 4;

endpackage

// File: rtl/pulse_meter_if.sv
// Signal bundle between pulse_meter and whatever consumes its measurements.
//   sig          measured asynchronous level input (driven by the slave side)
//   width        measured high time of the last accepted pulse
//   width_valid  1-cycle strobe; width and ovf update in the same cycle
//   ovf          the last accepted pulse saturated the counter
//   busy         a pulse is currently being timed
//   pulse_cnt    number of accepted pulses, wraps 255 -> 0
//   debug        low bits of the live width counter
// master: the meter itself.  slave: the consumer / stimulus side.
interface pulse_meter_if #(
  parameter int CTRLEN = 27
);
  import pulse_meter_pkg::*;

  logic                   sig;
  logic [CTRLEN-1:0]      width;
  logic                   width_valid;
  logic                   ovf;
  logic                   busy;
  logic [PULSE_CNT_W-1:0] pulse_cnt;
  logic [DEBUG_W-1:0]     debug;

  modport master (
    input  sig,
    output width, width_valid, ovf, busy, pulse_cnt, debug
  );

  modport slave (
    output sig,
    input  width, width_valid, ovf, busy, pulse_cnt, debug
  );

endinterface

// File: rtl/pulse_meter_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level input.
//   CLK  destination clock
//   RST  asynchronous active-high reset; both flops clear to 0
//   d    asynchronous input
//   q    input resynchronized to CLK (two cycles of latency)
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pulse_meter.sv
// Measures the high time of an asynchronous level input in CLK cycles.
// The input is resynchronized, then a three-state FSM (ARM / IDLE / MEASURE) times
// each high period. Pulses shorter than MIN_WIDTH synced cycles are discarded as
// glitches. An accepted pulse updates width/ovf, strobes width_valid for one cycle
// and increments pulse_cnt.
//   CLK   single clock, rising edge
//   RST   asynchronous active-high reset
//   pif   pulse_meter_if.master: sig in; width, width_valid, ovf, busy,
//         pulse_cnt and debug out
// Parameters:
//   CTRLEN     width of the cycle counter and of the width output
//   MIN_WIDTH  shortest accepted pulse in synced cycles (>= 1)
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CTRLEN    = 27,
  parameter int MIN_WIDTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  pulse_meter_if.master pif
);

  localparam logic [CTRLEN-1:0] CNT_MAX = '1;
  localparam logic [CTRLEN-1:0] CNT_ONE = CTRLEN'(1);
  localparam logic [CTRLEN-1:0] MIN_W   = CTRLEN'(MIN_WIDTH);

  logic sig_s;
  logic sig_d;

  state_t                 state_q, state_nxt;
  logic [CTRLEN-1:0]      cnt_q, cnt_nxt;
  logic [CTRLEN-1:0]      cnt_inc;
  logic                   ovf_int_q, ovf_int_nxt;
  logic [CTRLEN-1:0]      width_q, width_nxt;
  logic                   ovf_q, ovf_nxt;
  logic                   wv_q, wv_nxt;
  logic [PULSE_CNT_W-1:0] pc_q, pc_nxt;

  sync_2ff u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (pif.sig),
    .q   (sig_s)
  );

  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    ovf_int_nxt = ovf_int_q;
    width_nxt   = width_q;
    ovf_nxt     = ovf_q;
    wv_nxt      = 1'b0;
    pc_nxt      = pc_q;
    case (state_q)
      // A level already high when reset releases must not be timed as a pulse,
      // so nothing is armed until the synced input has been seen low.
      ST_ARM: begin
        if (!sig_s) state_nxt = ST_ARM == ST_ARM ? ST_IDLE : ST_ARM;
      end
      // The rising-edge cycle itself is the first counted cycle.
      ST_IDLE: begin
        if (sig_s && !sig_d) begin
          state_nxt   = ST_MEASURE;
          cnt_nxt     = CNT_ONE;
          ovf_int_nxt = (CNT_ONE == CNT_MAX);
        end
      end
      ST_MEASURE: begin
        if (sig_s) begin
          // Saturate instead of wrapping; ovf_int records that the ceiling was hit.
          if (cnt_q != CNT_MAX) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_MAX) ovf_int_nxt = 1'b1;
          end
        end else begin
          if (cnt_q >= MIN_W) begin
            width_nxt = cnt_q;
            ovf_nxt   = ovf_int_q;
            wv_nxt    = 1'b1;
            pc_nxt    = pc_q + 1'b1;
          end
          cnt_nxt     = '0;
          ovf_int_nxt = 1'b0;
          state_nxt   = ST_IDLE;
        end
      end
      default: begin
        state_nxt   = ST_ARM;
        cnt_nxt     = '0;
        ovf_int_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_ARM;
      sig_d     <= 1'b0;
      cnt_q     <= '0;
      ovf_int_q <= 1'b0;
      width_q   <= '0;
      ovf_q     <= 1'b0;
      wv_q      <= 1'b0;
      pc_q      <= '0;
    end else begin
      state_q   <= state_nxt;
      sig_d     <= sig_s;
      cnt_q     <= cnt_nxt;
      ovf_int_q <= ovf_int_nxt;
      width_q   <= width_nxt;
      ovf_q     <= ovf_nxt;
      wv_q      <= wv_nxt;
      pc_q      <= pc_nxt;
    end
  end

  assign pif.width       = width_q;
  assign pif.width_valid = wv_q;
  assign pif.ovf         = ovf_q;
  assign pif.busy        = (state_q == ST_MEASURE);
  assign pif.pulse_cnt   = pc_q;
  assign pif.debug       = DEBUG_W'(cnt_q);

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter with CTRLEN=8, MIN_WIDTH=4.
// sig is changed on falling edges and outputs are sampled on falling edges.
module tb_pulse_meter;

  localparam int CTRLEN    = 8;
  localparam int MIN_WIDTH = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  pulse_meter_if #(.CTRLEN(CTRLEN)) pif ();

  pulse_meter #(
    .CTRLEN    (CTRLEN),
    .MIN_WIDTH (MIN_WIDTH)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .pif (pif)
  );

  int total = 0;
  int bad   = 0;

  // Strobe / busy bookkeeping, written only here.
  int         n_strobe = 0;
  int         n_busy   = 0;
  logic [7:0] last_w   = '0;
  logic [7:0] prev_w   = '0;
  logic       last_ovf = 1'b0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (pif.width_valid === 1'b1) begin
        n_strobe = n_strobe + 1;
        prev_w   = last_w;
        last_w   = pif.width;
        last_ovf = pif.ovf;
      end
      if (pif.busy === 1'b1) n_busy = n_busy + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse(input int hi, input int lo);
    pif.sig = 1'b1;
    cyc(hi);
    pif.sig = 1'b0;
    cyc(lo);
  endtask

  task automatic test_reset();
    pif.sig = 1'b0;
    RST = 1'b1;
    cyc(3);
    total++; if (pif.width !== 8'd0) begin bad++; $display("FAIL rst_width got=%0d want=0", pif.width); end
    total++; if (pif.width_valid !== 1'b0) begin bad++; $display("FAIL rst_wv got=%b want=0", pif.width_valid); end
    total++; if (pif.ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", pif.ovf); end
    total++; if (pif.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", pif.busy); end
    total++; if (pif.pulse_cnt !== 8'd0) begin bad++; $display("FAIL rst_pcnt got=%0d want=0", pif.pulse_cnt); end
    total++; if (pif.debug !== 4'd0) begin bad++; $display("FAIL rst_debug got=%0d want=0", pif.debug); end
    RST = 1'b0;
    cyc(3);
  endtask

  task automatic test_basic();
    int s0, b0;
    s0 = n_strobe;
    b0 = n_busy;
    pif.sig = 1'b1;
    cyc(10);
    pif.sig = 1'b0;
    cyc(1);
    total++; if (pif.width_valid !== 1'b0) begin bad++; $display("FAIL lat_e1 got=%b want=0", pif.width_valid); end
    cyc(1);
    total++; if (pif.width_valid !== 1'b0) begin bad++; $display("FAIL lat_e2 got=%b want=0", pif.width_valid); end
    cyc(1);
    total++; if (pif.width_valid !== 1'b1) begin bad++; $display("FAIL lat_e3 got=%b want=1", pif.width_valid); end
    total++; if (pif.width !== 8'd10) begin bad++; $display("FAIL basic_width got=%0d want=10", pif.width); end
    cyc(1);
    total++; if (pif.width_valid !== 1'b0) begin bad++; $display("FAIL lat_e4 got=%b want=0", pif.width_valid); end
    cyc(2);
    total++; if (n_strobe - s0 != 1) begin bad++; $display("FAIL basic_strobes got=%0d want=1", n_strobe - s0); end
    total++; if (last_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", last_ovf); end
    total++; if (pif.pulse_cnt !== 8'd1) begin bad++; $display("FAIL basic_pcnt got=%0d want=1", pif.pulse_cnt); end
    total++; if (n_busy - b0 != 10) begin bad++; $display("FAIL basic_busy got=%0d want=10", n_busy - b0); end
  endtask

  task automatic test_glitch();
    int s0;
    s0 = n_strobe;
    pulse(3, 5);
    total++; if (n_strobe - s0 != 0) begin bad++; $display("FAIL glitch_strobes got=%0d want=0", n_strobe - s0); end
    total++; if (pif.width !== 8'd10) begin bad++; $display("FAIL glitch_width got=%0d want=10", pif.width); end
    total++; if (pif.pulse_cnt !== 8'd1) begin bad++; $display("FAIL glitch_pcnt got=%0d want=1", pif.pulse_cnt); end
    pulse(4, 5);
    total++; if (n_strobe - s0 != 1) begin bad++; $display("FAIL min_strobes got=%0d want=1", n_strobe - s0); end
    total++; if (pif.width !== 8'd4) begin bad++; $display("FAIL min_width got=%0d want=4", pif.width); end
    total++; if (pif.pulse_cnt !== 8'd2) begin bad++; $display("FAIL min_pcnt got=%0d want=2", pif.pulse_cnt); end
  endtask

  task automatic test_overflow();
    pulse(300, 5);
    total++; if (pif.width !== 8'd255) begin bad++; $display("FAIL ovf_width got=%0d want=255", pif.width); end
    total++; if (pif.ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", pif.ovf); end
    total++; if (pif.pulse_cnt !== 8'd3) begin bad++; $display("FAIL ovf_pcnt got=%0d want=3", pif.pulse_cnt); end
    pulse(20, 5);
    total++; if (pif.width !== 8'd20) begin bad++; $display("FAIL post_ovf_width got=%0d want=20", pif.width); end
    total++; if (pif.ovf !== 1'b0) begin bad++; $display("FAIL post_ovf_flag got=%b want=0", pif.ovf); end
    total++; if (pif.pulse_cnt !== 8'd4) begin bad++; $display("FAIL post_ovf_pcnt got=%0d want=4", pif.pulse_cnt); end
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = n_strobe;
    pif.sig = 1'b1;
    cyc(5);
    pif.sig = 1'b0;
    cyc(1);
    pif.sig = 1'b1;
    cyc(7);
    pif.sig = 1'b0;
    cyc(5);
    total++; if (n_strobe - s0 != 2) begin bad++; $display("FAIL b2b_strobes got=%0d want=2", n_strobe - s0); end
    total++; if (prev_w !== 8'd5) begin bad++; $display("FAIL b2b_first got=%0d want=5", prev_w); end
    total++; if (last_w !== 8'd7) begin bad++; $display("FAIL b2b_second got=%0d want=7", last_w); end
    total++; if (pif.pulse_cnt !== 8'd6) begin bad++; $display("FAIL b2b_pcnt got=%0d want=6", pif.pulse_cnt); end
  endtask

  task automatic test_wrap();
    int s0;
    s0 = n_strobe;
    for (int i = 0; i < 248; i++) pulse(4, 2);
    pulse(4, 5);
    total++; if (pif.pulse_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d want=255", pif.pulse_cnt); end
    pulse(4, 5);
    total++; if (pif.pulse_cnt !== 8'd0) begin bad++; $display("FAIL wrap_0 got=%0d want=0", pif.pulse_cnt); end
    total++; if (n_strobe - s0 != 250) begin bad++; $display("FAIL wrap_strobes got=%0d want=250", n_strobe - s0); end
    total++; if (pif.width !== 8'd4) begin bad++; $display("FAIL wrap_width got=%0d want=4", pif.width); end
  endtask

  task automatic test_arm();
    int s0, s1;
    RST = 1'b1;
    pif.sig = 1'b1;
    cyc(3);
    total++; if (pif.pulse_cnt !== 8'd0) begin bad++; $display("FAIL arm_rst_pcnt got=%0d want=0", pif.pulse_cnt); end
    total++; if (pif.width !== 8'd0) begin bad++; $display("FAIL arm_rst_width got=%0d want=0", pif.width); end
    RST = 1'b0;
    s0 = n_strobe;
    cyc(8);
    total++; if (n_strobe - s0 != 0) begin bad++; $display("FAIL arm_held_strobes got=%0d want=0", n_strobe - s0); end
    pif.sig = 1'b0;
    cyc(6);
    s1 = n_strobe;
    pulse(6, 5);
    total++; if (n_strobe - s1 != 1) begin bad++; $display("FAIL arm_strobes got=%0d want=1", n_strobe - s1); end
    total++; if (last_w !== 8'd6) begin bad++; $display("FAIL arm_width got=%0d want=6", last_w); end
    total++; if (last_ovf !== 1'b0) begin bad++; $display("FAIL arm_ovf got=%b want=0", last_ovf); end
  endtask

  task automatic test_midreset();
    int s0;
    pif.sig = 1'b1;
    cyc(52);
    total++; if (pif.debug !== 4'd2) begin bad++; $display("FAIL mid_debug got=%0d want=2", pif.debug); end
    total++; if (pif.busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", pif.busy); end
    #1 RST = 1'b1;
    #1;
    total++; if (pif.width !== 8'd0) begin bad++; $display("FAIL async_width got=%0d want=0", pif.width); end
    total++; if (pif.width_valid !== 1'b0) begin bad++; $display("FAIL async_wv got=%b want=0", pif.width_valid); end
    total++; if (pif.ovf !== 1'b0) begin bad++; $display("FAIL async_ovf got=%b want=0", pif.ovf); end
    total++; if (pif.busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b want=0", pif.busy); end
    total++; if (pif.pulse_cnt !== 8'd0) begin bad++; $display("FAIL async_pcnt got=%0d want=0", pif.pulse_cnt); end
    total++; if (pif.debug !== 4'd0) begin bad++; $display("FAIL async_debug got=%0d want=0", pif.debug); end
    pif.sig = 1'b0;
    cyc(2);
    RST = 1'b0;
    s0 = n_strobe;
    cyc(10);
    total++; if (n_strobe - s0 != 0) begin bad++; $display("FAIL mid_post_strobes got=%0d want=0", n_strobe - s0); end
    total++; if (pif.busy !== 1'b0) begin bad++; $display("FAIL mid_post_busy got=%b want=0", pif.busy); end
    total++; if (pif.pulse_cnt !== 8'd0) begin bad++; $display("FAIL mid_post_pcnt got=%0d want=0", pif.pulse_cnt); end
    pulse(5, 5);
    total++; if (pif.width !== 8'd5) begin bad++; $display("FAIL mid_rec_width got=%0d want=5", pif.width); end
    total++; if (pif.pulse_cnt !== 8'd1) begin bad++; $display("FAIL mid_rec_pcnt got=%0d want=1", pif.pulse_cnt); end
  endtask

  initial begin
    pif.sig = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_arm();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
